// File: rtl/bitonic_loader_if.sv
// bitonic_loader_if
//   Stream bundle between the word source, the loader and the sort network.
//   s_valid/s_ready/s_data/s_last : one word per beat into the loader
//   m_valid/m_ready/m_data/m_count: one packed frame out of the loader
//   Modports:
//     master - loader side (consumes the word stream, drives the frame)
//     slave  - environment side (drives words, consumes frames)
interface bitonic_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 2
);
    localparam int CW = $clog2(N + 1);

    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH*N-1:0] m_data;
    logic [CW-1:0]           m_count;

    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );
endinterface

// File: rtl/bitonic_loader.sv
// bitonic_loader
//   Serial-to-parallel front end of the bitonic sorter. Collects
//   N = 2**(ORDER+1) words from a valid/ready stream into one frame and
//   presents it, held stable, on a valid/ready output feeding the network.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous reset, active high (s_ready forced low while high)
//     bus  - bitonic_loader_if.master (word stream in, frame out)
//   Optional feature macro: BITONIC_LOADER_PAD_EN
//     defined   - s_last closes a frame early, empty slots get the pad value
//                 and m_count reports the real word count
//     undefined - s_last ignored, every frame is exactly N words

// One frame slot. A write takes the incoming word; a pad request loads the
// pad constant. The write and the pad are never requested in the same cycle.
module bitonic_loader_slot #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VAL    = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr,
    input  logic                  i_pad,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)        r_q <= '0;
        else if (i_wr)  r_q <= i_data;
        else if (i_pad) r_q <= PAD_VAL;
    end

    assign o_q = r_q;
endmodule

module bitonic_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ORDER      = 0,
    parameter int POLARITY   = 0,
    parameter int SIGNED     = 0
) (
    input  logic              clk,
    input  logic              rst,
    bitonic_loader_if.master  bus
);
    localparam int N  = 2 ** (ORDER + 1);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    // Pad sorts to the tail: the largest value for an ascending network,
    // the smallest for a descending one, in the element's number system.
    localparam logic [DATA_WIDTH-1:0] PAD_MAX_U = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] PAD_MAX_S = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] PAD_MIN_U = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] PAD_MIN_S = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] PAD_VAL =
        (POLARITY == 0) ? ((SIGNED != 0) ? PAD_MAX_S : PAD_MAX_U)
                        : ((SIGNED != 0) ? PAD_MIN_S : PAD_MIN_U);

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t                           r_state;
    logic [IW-1:0]                    r_idx;
    logic                             r_valid;
    logic [CW-1:0]                    r_count;

    logic                             w_s_ready;
    logic                             w_beat;
    logic                             w_close;
    logic [CW-1:0]                    w_count;
    logic [N-1:0]                     w_wr;
    logic [N-1:0]                     w_pad;
    logic [N-1:0][DATA_WIDTH-1:0]     w_data;

    // s_ready comes from the state register; rst only gates it so that no
    // word is taken during reset. No path from s_* to m_* exists.
    assign w_s_ready = (r_state == S_FILL) && !rst;
    assign w_beat    = bus.s_valid && w_s_ready;

`ifdef BITONIC_LOADER_PAD_EN
    assign w_close = (r_idx == IW'(N - 1)) || bus.s_last;
    assign w_count = CW'(r_idx) + CW'(1);
`else
    assign w_close = (r_idx == IW'(N - 1));
    assign w_count = CW'(N);
`endif

    // Per-slot write strobes: the beat lands in slot r_idx; on an early
    // close every slot above r_idx is padded in the same cycle.
    for (genvar k = 0; k < N; k++) begin : g_slot
        assign w_wr[k] = w_beat && (r_idx == IW'(k));
`ifdef BITONIC_LOADER_PAD_EN
        assign w_pad[k] = w_beat && w_close && (IW'(k) > r_idx);
`else
        assign w_pad[k] = 1'b0;
`endif
        bitonic_loader_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .PAD_VAL    (PAD_VAL)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_wr   (w_wr[k]),
            .i_pad  (w_pad[k]),
            .i_data (bus.s_data),
            .o_q    (w_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_beat) begin
                        if (w_close) begin
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                            r_idx   <= '0;
                            r_count <= w_count;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.m_ready) begin
                        r_state <= S_FILL;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_valid;
    assign bus.m_data  = w_data;
    assign bus.m_count = r_count;
endmodule

// File: tb/tb_bitonic_loader.sv
module tb_bitonic_loader;
    localparam int DW = 16;
    localparam int N  = 4;
`ifdef BITONIC_LOADER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sv = 1'b0, sl = 1'b0, mr = 1'b0;
    logic [DW-1:0] sd = '0;

    always #5 clk = ~clk;

    // Two loaders on the same stream: ascending/unsigned and descending/signed.
    bitonic_loader_if #(.DATA_WIDTH(DW), .N(N)) if_a ();
    bitonic_loader_if #(.DATA_WIDTH(DW), .N(N)) if_d ();

    assign if_a.s_valid = sv; assign if_a.s_data = sd; assign if_a.s_last = sl; assign if_a.m_ready = mr;
    assign if_d.s_valid = sv; assign if_d.s_data = sd; assign if_d.s_last = sl; assign if_d.m_ready = mr;

    bitonic_loader #(.DATA_WIDTH(DW), .ORDER(1), .POLARITY(0), .SIGNED(0))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    bitonic_loader #(.DATA_WIDTH(DW), .ORDER(1), .POLARITY(1), .SIGNED(1))
        u_d (.clk(clk), .rst(rst), .bus(if_d));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a list of accepted words and a "frame presented" flag.
    logic [DW-1:0] acc[$];
    bit            hold = 1'b0;
    logic [63:0]   exp_a = '0, exp_d = '0;
    logic [2:0]    exp_cnt = '0;

    // Observations from the most recent step / handshake.
    logic          smp_rdy, smp_vld;
    logic [63:0]   smp_data;
    logic [2:0]    smp_cnt;
    int            hs = 0;
    logic [63:0]   last_a, last_d;
    logic [2:0]    last_cnt;

    task automatic model_check();
        chk("s_ready_a", 64'(if_a.s_ready), 64'(!rst && !hold));
        chk("s_ready_d", 64'(if_d.s_ready), 64'(!rst && !hold));
        chk("m_valid_a", 64'(if_a.m_valid), 64'(hold));
        chk("m_valid_d", 64'(if_d.m_valid), 64'(hold));
        if (hold) begin
            chk("m_data_a",  if_a.m_data,       exp_a);
            chk("m_data_d",  if_d.m_data,       exp_d);
            chk("m_count_a", 64'(if_a.m_count), 64'(exp_cnt));
            chk("m_count_d", 64'(if_d.m_count), 64'(exp_cnt));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            hold = 1'b0;
            acc.delete();
        end else if (!hold) begin
            if (sv) begin
                acc.push_back(sd);
                if (acc.size() == N || (PAD && sl)) begin
                    for (int k = 0; k < N; k++) begin
                        exp_a[16*k +: 16] = (k < acc.size()) ? acc[k] : 16'hFFFF;
                        exp_d[16*k +: 16] = (k < acc.size()) ? acc[k] : 16'h8000;
                    end
                    exp_cnt = 3'(acc.size());
                    hold = 1'b1;
                    acc.delete();
                end
            end
        end else if (mr) begin
            hold = 1'b0;
        end
    endtask

    // One clock: drive inputs at the falling edge, compare before the rising
    // edge, then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic m);
        @(negedge clk);
        rst = r; sv = v; sd = d; sl = l; mr = m;
        #1;
        smp_rdy = if_a.s_ready; smp_vld = if_a.m_valid;
        smp_data = if_a.m_data; smp_cnt = if_a.m_count;
        model_check();
        if (!rst && if_a.m_valid && mr) begin
            hs++;
            last_a = if_a.m_data; last_d = if_d.m_data; last_cnt = if_a.m_count;
        end
        @(posedge clk);
        model_update();
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sl;
        logic          mr;
        logic          e_rdy;
        logic          e_vld;
        logic [63:0]   e_data;
        logic [2:0]    e_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Frame 4,1,3,2 taken at once, then the same frame held 5 cycles
        // under back-pressure with junk offered on s_data meanwhile.
        tbl[0]  = '{1'b1, 16'd4,     1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[1]  = '{1'b1, 16'd1,     1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[2]  = '{1'b1, 16'd3,     1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[3]  = '{1'b1, 16'd2,     1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[4]  = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 1'b1, 64'h0002_0003_0001_0004, 3'd4};
        tbl[5]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[6]  = '{1'b1, 16'd4,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[7]  = '{1'b1, 16'd1,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[8]  = '{1'b1, 16'd3,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};
        tbl[9]  = '{1'b1, 16'd2,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0002_0003_0001_0004, 3'd4};
        tbl[15] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 1'b1, 64'h0002_0003_0001_0004, 3'd4};
        tbl[16] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0};

        // Reset, then reset-state check.
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        chk("rst_s_ready", 64'(smp_rdy), 64'(0));
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_m_valid", 64'(smp_vld), 64'(0));
        chk("rst_m_data",  smp_data,     64'h0);
        chk("rst_m_count", 64'(smp_cnt), 64'(0));

        for (int i = 0; i < 17; i++) begin
            step(1'b0, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
            chk($sformatf("tbl%0d_s_ready", i), 64'(smp_rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_m_valid", i), 64'(smp_vld), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_m_data", i),  smp_data,     tbl[i].e_data);
                chk($sformatf("tbl%0d_m_count", i), 64'(smp_cnt), 64'(tbl[i].e_cnt));
            end
        end

        // s_valid every other cycle, 8 words, junk data on idle cycles.
        hs = 0;
        for (int i = 0; i < 16; i++)
            step(1'b0, (i % 2) == 0, (i % 2) == 0 ? 16'(100 + i / 2) : 16'hBEEF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3_frames", 64'(hs), 64'(2));
        chk("t3_frame2", last_a, 64'h006B_006A_0069_0068);

        // Reset after 2 of 4 words; earlier words must not appear.
        hs = 0;
        step(1'b0, 1'b1, 16'd11, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd12, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'd13, 1'b0, 1'b1);
        chk("t4_rst_s_ready", 64'(smp_rdy), 64'(0));
        step(1'b0, 1'b1, 16'd9, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd8, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd6, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        chk("t4_frames", 64'(hs), 64'(1));
        chk("t4_frame",  last_a, 64'h0006_0007_0008_0009);

        hs = 0;
`ifdef BITONIC_LOADER_PAD_EN
        step(1'b0, 1'b1, 16'd5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd7, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        chk("t5_frame_asc", last_a, 64'hFFFF_FFFF_0007_0005);
        chk("t5_frame_dsc", last_d, 64'h8000_8000_0007_0005);
        chk("t5_count",     64'(last_cnt), 64'(2));
        step(1'b0, 1'b1, 16'h0003, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        chk("t6_frame_dsc", last_d, 64'h8000_8000_8000_0003);
        chk("t6_count",     64'(last_cnt), 64'(1));
        chk("t56_frames",   64'(hs), 64'(2));
`else
        // s_last must have no effect: the frame still needs four words.
        step(1'b0, 1'b1, 16'd5, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'd7, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'd1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        chk("t5_frames", 64'(hs), 64'(1));
        chk("t5_frame",  last_a, 64'h0002_0001_0007_0005);
        chk("t5_count",  64'(last_cnt), 64'(4));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(63) == 0, $urandom_range(9) < 7, 16'($urandom),
                 $urandom_range(3) == 0, $urandom_range(9) < 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
